sample_scheduler: RTL

Periodic sensor-sampling sequencer for the weather station FPGA. A clock prescaler and a period counter generate a round request. Each round steps round-robin through NUM_CH sensor interfaces. For each channel it issues a one-cycle start pulse, waits for done with a timeout, and latches the returned 16-bit sample for the display/logging path.

---
 rtl/sample_scheduler.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/sample_scheduler.sv
// Periodic round-robin sensor sampler: a prescaled period counter raises round
// requests, and each round starts every channel in turn, waits for done or timeout, and latches the sample.
module sample_scheduler #(
  parameter int unsigned NUM_CH       = 4,
  parameter logic [15:0] TICK_DIV     = 16'd50000,
  parameter logic [7:0]  PERIOD_TICKS = 8'd10,
  parameter logic [15:0] TIMEOUT      = 16'd1000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              en_in,
  input  logic [NUM_CH-1:0] done_in,
  input  logic [15:0]       data_in,
  output logic [NUM_CH-1:0] start_out,
  output logic [1:0]        ch_out,
  output logic [15:0]       sample_out,
  output logic              sample_valid_out,
  output logic              timeout_out,
  output logic              round_done_out,
  output logic              overrun_out,
  output logic              busy_out
);

  localparam logic [15:0] TICK_LAST   = TICK_DIV - 16'd1;
  localparam logic [7:0]  PERIOD_LAST = PERIOD_TICKS - 8'd1;
  localparam logic [15:0] TO_LAST     = TIMEOUT - 16'd1;
  localparam logic [1:0]  LAST_CH     = 2'(NUM_CH - 1);

  typedef enum logic [2:0] {IDLE, START, WAIT, STORE, NEXT} state_t;

  state_t      state_q, state_d;
  logic [15:0] tickCnt_q, tickCnt_d;
  logic [7:0]  periodCnt_q, periodCnt_d;
  logic [15:0] toCnt_q, toCnt_d;
  logic [1:0]  ch_q, ch_d;
  logic [15:0] sample_q, sample_d;
  logic        timedOut_q, timedOut_d;

  logic        tick;
  logic        roundReq;
  logic [3:0]  donePad;
  logic [3:0]  startPad;
  logic        selDone;

  // Prescaler and period counter run freely whenever enabled, regardless of the FSM.
  always_comb begin
    tick        = en_in && (tickCnt_q == TICK_LAST);
    roundReq    = tick && (periodCnt_q == PERIOD_LAST);
    tickCnt_d   = tickCnt_q;
    periodCnt_d = periodCnt_q;
    if (en_in) begin
      tickCnt_d = tick ? 16'd0 : tickCnt_q + 16'd1;
    end
    if (tick) begin
      periodCnt_d = (periodCnt_q == PERIOD_LAST) ? 8'd0 : periodCnt_q + 8'd1;
    end
  end

  // Pad to four channels so a 2-bit channel index is always in range.
  always_comb begin
    donePad                = 4'd0;
    donePad[NUM_CH-1:0]    = done_in;
    selDone                = donePad[ch_q];
  end

  always_comb begin
    state_d          = state_q;
    ch_d             = ch_q;
    sample_d         = sample_q;
    toCnt_d          = toCnt_q;
    timedOut_d       = timedOut_q;
    startPad         = 4'd0;
    sample_valid_out = 1'b0;
    timeout_out      = 1'b0;
    round_done_out   = 1'b0;
    overrun_out      = roundReq && (state_q != IDLE);

    case (state_q)
      IDLE: begin
        if (roundReq) begin
          ch_d    = 2'd0;
          state_d = START;
        end
      end
      START: begin
        startPad[ch_q] = 1'b1;
        toCnt_d        = 16'd0;
        timedOut_d     = 1'b0;
        state_d        = WAIT;
      end
      // A done arriving on the final timeout cycle still counts as a capture.
      WAIT: begin
        toCnt_d = toCnt_q + 16'd1;
        if (selDone) begin
          sample_d = data_in;
          state_d  = STORE;
        end else if (toCnt_q == TO_LAST) begin
          timedOut_d = 1'b1;
          state_d    = NEXT;
        end
      end
      STORE: begin
        sample_valid_out = 1'b1;
        state_d          = NEXT;
      end
      NEXT: begin
        timeout_out = timedOut_q;
        if (ch_q == LAST_CH) begin
          round_done_out = 1'b1;
          state_d        = IDLE;
        end else begin
          ch_d    = ch_q + 2'd1;
          state_d = START;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q     <= IDLE;
      tickCnt_q   <= 16'd0;
      periodCnt_q <= 8'd0;
      toCnt_q     <= 16'd0;
      ch_q        <= 2'd0;
      sample_q    <= 16'd0;
      timedOut_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tickCnt_q   <= tickCnt_d;
      periodCnt_q <= periodCnt_d;
      toCnt_q     <= toCnt_d;
      ch_q        <= ch_d;
      sample_q    <= sample_d;
      timedOut_q  <= timedOut_d;
    end
  end

  assign start_out  = startPad[NUM_CH-1:0];
  assign ch_out     = ch_q;
  assign sample_out = sample_q;
  assign busy_out   = (state_q != IDLE);

endmodule
